// File: rtl/adder_chk_pkg.sv
// Shared types and sizing helpers for the adder checker.
package adder_chk_pkg;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  // Number of distinct {a,b,cin} operand combinations, as a bit count.
  function automatic int unsigned combo_bits(int unsigned width);
    return 2 * width + 1;
  endfunction

  // Samples expected in a complete run: SWEEPS exhaustive passes.
  function automatic logic [63:0] term_count(int unsigned width, int unsigned sweeps);
    return 64'(sweeps) << combo_bits(width);
  endfunction

endpackage

// File: rtl/adder_ref_model.sv
// Golden WIDTH+1-bit result {carry,sum} for the adder under check.
module adder_ref_model #(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH:0]   exp_o
);

  assign exp_o = (WIDTH+1)'(a_i) + (WIDTH+1)'(b_i) + (WIDTH+1)'(cin_i);

endmodule

// File: rtl/adder_2_checker.sv
// Run-based response checker for a WIDTH-bit adder with error/vector counts.
// Define ADDER_CHK_COVERAGE_EN to track operand coverage; otherwise cov_full is 1.
module adder_2_checker
  import adder_chk_pkg::*;
#(
  parameter int WIDTH  = 2,
  parameter int SWEEPS = 5,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [WIDTH-1:0] sum,
  input  logic             out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             mismatch,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] vec_count,
  output logic             cov_full
);

  localparam int          COMBOS = 1 << combo_bits(WIDTH);
  localparam logic [63:0] TERM   = term_count(WIDTH, SWEEPS);

  state_e           state_q;
  logic [CNT_W-1:0] err_q, err_d;
  logic [CNT_W-1:0] vec_q, vec_d;
  logic             mism_q;
  logic [WIDTH:0]   exp_w;

  adder_ref_model #(.WIDTH(WIDTH)) u_ref (
    .a_i   (a),
    .b_i   (b),
    .cin_i (cin),
    .exp_o (exp_w)
  );

  logic take, bad, launch, last;
  assign take   = (state_q == S_RUN) && in_valid;
  assign bad    = take && (exp_w != {out, sum});
  assign launch = start && (state_q != S_RUN);
  // Terminal compare is done wide so a narrow saturated counter simply never ends the run.
  assign last   = take && !(&vec_q) && ((64'(vec_q) + 64'd1) == TERM);

  always_comb begin
    err_d = err_q;
    vec_d = vec_q;
    if (launch) begin
      err_d = '0;
      vec_d = '0;
    end else if (take) begin
      if (!(&vec_q))        vec_d = vec_q + 1'b1;
      if (bad && !(&err_q)) err_d = err_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      err_q   <= '0;
      vec_q   <= '0;
      mism_q  <= 1'b0;
    end else begin
      err_q  <= err_d;
      vec_q  <= vec_d;
      mism_q <= bad;
      case (state_q)
        S_IDLE:  if (start) state_q <= S_RUN;
        S_RUN:   if (last)  state_q <= S_DONE;
        S_DONE:  if (start) state_q <= S_RUN;
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef ADDER_CHK_COVERAGE_EN
  logic [COMBOS-1:0] cov_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cov_q <= '0;
    else if (launch) cov_q <= '0;
    else if (take)   cov_q[{a, b, cin}] <= 1'b1;
  end

  assign cov_full = &cov_q;
`else
  assign cov_full = 1'b1;
`endif

  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign pass      = done && (err_q == '0) && cov_full;
  assign mismatch  = mism_q;
  assign err_count = err_q;
  assign vec_count = vec_q;

endmodule

// File: tb/tb_adder_2_checker.sv
// Randomized bench for adder_2_checker against a behavioural run model.
module tb_adder_2_checker;

  localparam int TC = 5 * 32;

  logic       clk = 1'b0;
  logic       rst_n, start, in_valid, cin, out;
  logic [1:0] a, b, sum;
  logic       busy, done, pass, mismatch, cov_full;
  logic [15:0] err_count, vec_count;

  // Narrow-counter instance fed a response that is always wrong.
  logic [1:0] sum2;
  logic       busy2, done2, pass2, mismatch2, cov_full2;
  logic [3:0] err_count2, vec_count2;
  assign sum2 = sum ^ 2'b01;

  adder_2_checker #(.WIDTH(2), .SWEEPS(5), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .a(a), .b(b), .cin(cin), .sum(sum), .out(out),
    .busy(busy), .done(done), .pass(pass), .mismatch(mismatch),
    .err_count(err_count), .vec_count(vec_count), .cov_full(cov_full)
  );

  adder_2_checker #(.WIDTH(2), .SWEEPS(5), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .a(a), .b(b), .cin(cin), .sum(sum2), .out(out),
    .busy(busy2), .done(done2), .pass(pass2), .mismatch(mismatch2),
    .err_count(err_count2), .vec_count(vec_count2), .cov_full(cov_full2)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model of one run: 0 idle, 1 running, 2 finished.
  int m_state, m_vec, m_err;
  bit m_mis;
  bit m_cov[32];

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_covfull();
`ifdef ADDER_CHK_COVERAGE_EN
    for (int i = 0; i < 32; i++) if (!m_cov[i]) return 1'b0;
`endif
    return 1'b1;
  endfunction

  task automatic m_reset();
    m_state = 0; m_vec = 0; m_err = 0; m_mis = 0;
    for (int i = 0; i < 32; i++) m_cov[i] = 0;
  endtask

  task automatic check_outs(string tag);
    chk({tag, ".busy"},  busy,      m_state == 1);
    chk({tag, ".done"},  done,      m_state == 2);
    chk({tag, ".mis"},   mismatch,  m_mis);
    chk({tag, ".err"},   err_count, m_err);
    chk({tag, ".vec"},   vec_count, m_vec);
    chk({tag, ".cov"},   cov_full,  m_covfull());
    chk({tag, ".pass"},  pass,      (m_state == 2) && (m_err == 0) && m_covfull());
  endtask

  // One clock: drive at negedge, update model at posedge, check at next negedge.
  task automatic cyc(string tag, bit st, bit v, int ai, int bi, int ci, int resp);
    start = st; in_valid = v; a = 2'(ai); b = 2'(bi); cin = ci[0];
    {out, sum} = 3'(resp);
    @(posedge clk);
    if (st && m_state != 1) begin
      m_state = 1; m_vec = 0; m_err = 0; m_mis = 0;
      for (int i = 0; i < 32; i++) m_cov[i] = 0;
    end else if (m_state == 1 && v) begin
      m_mis = (resp != ai + bi + ci);
      if (m_vec < 65535) m_vec++;
      if (m_mis && m_err < 65535) m_err++;
      m_cov[ai * 8 + bi * 2 + ci] = 1;
      if (m_vec == TC) m_state = 2;
    end else begin
      m_mis = 0;
    end
    @(negedge clk);
    start = 0; in_valid = 0;
    check_outs(tag);
  endtask

  // Optional idle cycle with junk operands, sometimes carrying a stray start.
  task automatic maybe_gap(string tag);
    if ($urandom_range(0, 3) == 0)
      cyc(tag, $urandom_range(0, 4) == 0, 0, $urandom_range(0, 3), $urandom_range(0, 3),
          $urandom_range(0, 1), $urandom_range(0, 7));
  endtask

  task automatic sweep(string tag, int bad_a, int bad_b, int bad_c, bit skip_cin1);
    cyc({tag, "_start"}, 1, 0, 0, 0, 0, 0);
    for (int s = 0; s < (skip_cin1 ? 10 : 5); s++)
      for (int ai = 0; ai < 4; ai++)
        for (int bi = 0; bi < 4; bi++)
          for (int ci = 0; ci < 2; ci++) begin
            int r;
            if (skip_cin1 && ci == 1) continue;
            r = ai + bi + ci;
            if (s == 2 && ai == bad_a && bi == bad_b && ci == bad_c) r = 3'b010;
            maybe_gap({tag, "_gap"});
            cyc(tag, $urandom_range(0, 9) == 0, 1, ai, bi, ci, r);
          end
  endtask

  initial begin
    m_reset();
    rst_n = 0; start = 0; in_valid = 0; a = 0; b = 0; cin = 0; sum = 0; out = 0;
    #3;
    check_outs("reset");
    @(negedge clk); rst_n = 1;
    @(negedge clk);

    // Valid samples while idle must be ignored.
    for (int i = 0; i < 4; i++) cyc("idle_vld", 0, 1, i, 3 - i, i & 1, 0);

    sweep("sweep", -1, -1, -1, 0);
    chk("sweep_done", done, 1);
    chk("sweep_pass", pass, 1);
    chk("cnt4_err_sat", err_count2, 15);
    chk("cnt4_vec_sat", vec_count2, 15);
    chk("cnt4_busy", busy2, 1);

    // Samples after the run completes must not count.
    for (int i = 0; i < 3; i++) cyc("done_vld", 0, 1, i, i, 1, 0);

    sweep("inject", 3, 3, 1, 0);
    chk("inject_err", err_count, 1);
    chk("inject_pass", pass, 0);

    sweep("nocin", -1, -1, -1, 1);
    chk("nocin_done", done, 1);
`ifdef ADDER_CHK_COVERAGE_EN
    chk("nocin_pass", pass, 0);
`else
    chk("nocin_pass", pass, 1);
`endif

    // Reset mid-run, then a fresh random run.
    cyc("mid_start", 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 50; i++) begin
      int ai = $urandom_range(0, 3), bi = $urandom_range(0, 3), ci = $urandom_range(0, 1);
      cyc("mid", 0, 1, ai, bi, ci, ai + bi + ci);
    end
    rst_n = 0;
    #1;
    m_reset();
    check_outs("async_rst");
    chk("async_rst_vec4", vec_count2, 0);
    @(negedge clk); rst_n = 1;
    @(negedge clk);

    cyc("rnd_start", 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < TC; i++) begin
      int ai = $urandom_range(0, 3), bi = $urandom_range(0, 3), ci = $urandom_range(0, 1);
      int r = ai + bi + ci;
      if ($urandom_range(0, 7) == 0) r = r ^ $urandom_range(1, 7);
      maybe_gap("rnd_gap");
      cyc("rnd", $urandom_range(0, 9) == 0, 1, ai, bi, ci, r);
    end
    chk("rnd_done", done, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adder_2_checker.md
ADDER_2_CHECKER -- requirements
Module: adder_2_checker

Interface
REQ-001 SHALL have parameter WIDTH, default 2, meaning operand width of the adder under check.
REQ-002 SHALL have parameter SWEEPS, default 5, meaning number of full exhaustive passes expected per run.
REQ-003 SHALL have parameter CNT_W, default 16, meaning width of err_count and vec_count.
REQ-004 Ports: clk  in  1  single clock, all logic on rising edge.
REQ-005 Ports: rst_n  in  1  asynchronous active-low reset.
REQ-006 Ports: start  in  1  one-cycle pulse that begins a checking run.
REQ-007 Ports: in_valid  in  1  response sample below is valid this cycle.
REQ-008 Ports: a, b  in  WIDTH  operands applied to the adder under check.
REQ-009 Ports: cin  in  1  carry-in applied.
REQ-010 Ports: sum  in  WIDTH, out  in  1  sum and carry-out returned by the adder under check.
REQ-011 Ports: busy  out  1  run in progress; done  out  1  run complete (level); pass  out  1  valid when done.
REQ-012 Ports: mismatch  out  1  one-cycle pulse per failing sample; err_count, vec_count  out  CNT_W; cov_full  out  1  every operand combination seen.

Function
REQ-013 FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-014 IDLE->RUN on start; RUN->DONE on the cycle vec_count reaches SWEEPS*2^(2*WIDTH+1); DONE->RUN on start; no other transitions.
REQ-015 On entry to RUN: err_count, vec_count, coverage bitmap cleared in the same edge that accepts start.
REQ-016 In RUN, each in_valid cycle: expected {carry,sum} = a + b + cin computed at WIDTH+1 bits, compared with {out,sum}.
REQ-017 Latency: mismatch and err_count update one cycle after the sampled in_valid; vec_count increments on the same edge.
REQ-018 in_valid outside RUN SHALL be ignored (no count, no mismatch).
REQ-019 err_count and vec_count SHALL saturate at all-ones, never wrap.
REQ-020 Samples beyond the terminal count in the same cycle as the RUN->DONE edge SHALL not be counted.
REQ-021 busy = (state==RUN); done = (state==DONE); pass = done && err_count==0 && cov_full.
REQ-022 start while in RUN SHALL be ignored.
REQ-023 Worst case 2*WIDTH+1 covers 32 combinations at default width.

Reset
REQ-024 rst_n low: state IDLE, busy/done/pass/mismatch 0, counts 0, bitmap 0, immediately and asynchronously.
REQ-025 Reset mid-run SHALL abandon the run; no partial done or pass.
REQ-026 Deassertion is synchronous to clk by the integrating level; block needs no internal synchronizer.

Configuration
REQ-027 Macro ADDER_CHK_COVERAGE_EN defined: 2^(2*WIDTH+1)-bit bitmap indexed by {a,b,cin}, bit set on each counted sample; cov_full = all bits set.
REQ-028 Macro undefined: no bitmap synthesized, cov_full tied 1, pass depends only on err_count.

Structure
REQ-029 Package adder_chk_pkg SHALL hold the state enum and the terminal-count/vector-count width helper constants.
REQ-030 Sub-module adder_ref_model SHALL compute the WIDTH+1-bit expected result combinationally; checker instantiates one copy.

Verification
REQ-031 Exhaustive sweep of correct adder, SWEEPS=5, cin toggled fastest, b then a -> done after 160 samples, err_count 0, cov_full 1, pass 1.
REQ-032 Inject a=3,b=3,cin=1 returning sum=2'b10,out=0 once -> one mismatch pulse one cycle later, err_count 1, pass 0.
REQ-033 Sweep omitting every cin=1 sample, 160 samples total (with coverage macro) -> done, err_count 0, cov_full 0, pass 0; without macro -> pass 1.
REQ-034 rst_n low after 50 samples of a run -> outputs zero immediately; later start runs cleanly from count 0.
REQ-035 CNT_W=4, always-failing adder -> err_count sticks at 15, vec_count sticks at 15, no wrap.
REQ-036 in_valid pulses in IDLE and start pulses during RUN -> no count change, run continues unaffected.
